// File: rtl/seq_share_arb.sv
// Two-requester round-robin arbiter sharing one timed IDLE -> S1 -> S2 sequence.
// The owner receives a done pulse on S2 completion or an abort pulse if it withdraws early.
module seq_share_arb #(
  parameter int unsigned S1_LEN = 5,
  parameter int unsigned S2_LEN = 7,
  parameter int unsigned CW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] state_c,
  output logic       busy,
  output logic [1:0] done,
  output logic [1:0] abort
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StS1   = 2'b01,
    StS2   = 2'b10,
    StBad  = 2'b11
  } state_e;

  localparam logic [CW-1:0] S1Last = CW'(S1_LEN - 1);
  localparam logic [CW-1:0] S2Last = CW'(S2_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          lp_q, lp_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    abort_q, abort_d;

  logic owner;
  logic owner_req;
  logic win;

  // gnt_q is one-hot while a sequence is active, so bit 1 names the owner
  assign owner     = gnt_q[1];
  assign owner_req = req[owner];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    lp_d    = lp_q;
    done_d  = 2'b00;
    abort_d = 2'b00;
    win     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        gnt_d = 2'b00;
        if (req != 2'b00) begin
          win     = (req == 2'b11) ? ~lp_q : req[1];
          state_d = StS1;
          gnt_d   = win ? 2'b10 : 2'b01;
        end
      end
      StS1: begin
        if (!owner_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          gnt_d   = 2'b00;
          abort_d = gnt_q;
          lp_d    = owner;
        end else if (en) begin
          if (cnt_q == S1Last) begin
            state_d = StS2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StS2: begin
        // Completion on the final tick wins over a simultaneous request drop
        if (en && (cnt_q == S2Last)) begin
          state_d = StIdle;
          cnt_d   = '0;
          gnt_d   = 2'b00;
          done_d  = gnt_q;
          lp_d    = owner;
        end else if (!owner_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          gnt_d   = 2'b00;
          abort_d = gnt_q;
          lp_d    = owner;
        end else if (en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      lp_q    <= 1'b1;
      done_q  <= 2'b00;
      abort_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      lp_q    <= lp_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign gnt     = gnt_q;
  assign state_c = state_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_seq_share_arb.sv
// Bench for seq_share_arb: a countdown-based phase model checked every cycle, plus directed
// scenarios with literal expectations at hand-computed cycles.
module tb_seq_share_arb;

  localparam int unsigned S1Len = 5;
  localparam int unsigned S2Len = 7;
  localparam int unsigned Cw    = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] state_c;
  logic       busy;
  logic [1:0] done;
  logic [1:0] abort;

  int checks;
  int errors;

  seq_share_arb #(
    .S1_LEN(S1Len),
    .S2_LEN(S2Len),
    .CW    (Cw)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .state_c(state_c),
    .busy   (busy),
    .done   (done),
    .abort  (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0/1/2, owner index, ticks remaining in the current phase
  int         m_phase;
  int         m_left;
  logic       m_owner;
  logic       m_lp;
  logic [1:0] m_done;
  logic [1:0] m_abort;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_owner <= 1'b0;
      m_lp    <= 1'b1;
      m_done  <= 2'b00;
      m_abort <= 2'b00;
    end else begin
      m_done  <= 2'b00;
      m_abort <= 2'b00;
      if (m_phase == 0) begin
        if (req != 2'b00) begin
          m_phase <= 1;
          m_left  <= S1Len;
          m_owner <= (req == 2'b11) ? !m_lp : req[1];
        end
      end else if (m_phase == 2 && en && m_left == 1) begin
        m_phase <= 0;
        m_done  <= m_owner ? 2'b10 : 2'b01;
        m_lp    <= m_owner;
      end else if (!req[m_owner]) begin
        m_phase <= 0;
        m_abort <= m_owner ? 2'b10 : 2'b01;
        m_lp    <= m_owner;
      end else if (en) begin
        if (m_left == 1) begin
          m_phase <= 2;
          m_left  <= S2Len;
        end else begin
          m_left <= m_left - 1;
        end
      end
    end
  end

  function automatic logic [1:0] exp_gnt();
    if (m_phase == 0) return 2'b00;
    return m_owner ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on a negedge with reset released: that cycle is cycle 0
  task automatic do_reset(input logic [1:0] r, input logic e);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    en    = 1'b0;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_state", state_c, 2'b00);
    chk("rst_pulses", done | abort, 2'b00);
    wait_neg(2);
    rst_n = 1'b1;
    req   = r;
    en    = e;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 2'b00;
    en     = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("cmp_gnt", gnt, exp_gnt());
        chk("cmp_state", state_c, 2'(m_phase));
        chk("cmp_busy", {1'b0, busy}, {1'b0, m_phase != 0});
        chk("cmp_done", done, m_done);
        chk("cmp_abort", abort, m_abort);
      end
    join_none

    // Single requester, en held: S1 at 1, S2 at 6, done at 13
    do_reset(2'b01, 1'b1);
    wait_neg(1);
    chk("t1_gnt_c1", gnt, 2'b01);
    chk("t1_state_c1", state_c, 2'b01);
    wait_neg(5);
    chk("t1_state_c6", state_c, 2'b10);
    wait_neg(7);
    chk("t1_done_c13", done, 2'b01);
    chk("t1_state_c13", state_c, 2'b00);
    chk("t1_gnt_c13", gnt, 2'b00);
    req = 2'b00;
    wait_neg(2);

    // Both requesting: round-robin 0, 1, 0
    do_reset(2'b11, 1'b1);
    wait_neg(1);
    chk("t2_gnt_c1", gnt, 2'b01);
    wait_neg(12);
    chk("t2_done_c13", done, 2'b01);
    chk("t2_state_c13", state_c, 2'b00);
    wait_neg(1);
    chk("t2_gnt_c14", gnt, 2'b10);
    wait_neg(12);
    chk("t2_done_c26", done, 2'b10);
    wait_neg(1);
    chk("t2_gnt_c27", gnt, 2'b01);

    // en alternating: S1 spans cycles 1..10
    do_reset(2'b01, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      wait_neg(1);
      en = (k % 2 == 0);
      if (k == 1)  chk("t3_state_c1", state_c, 2'b01);
      if (k == 10) chk("t3_state_c10", state_c, 2'b01);
      if (k == 11) chk("t3_state_c11", state_c, 2'b10);
    end

    // Drop at S2 cnt=3 -> abort
    do_reset(2'b01, 1'b1);
    wait_neg(9);
    chk("t4_state_c9", state_c, 2'b10);
    req = 2'b00;
    wait_neg(1);
    chk("t4_abort", abort, 2'b01);
    chk("t4_done", done, 2'b00);
    chk("t4_gnt", gnt, 2'b00);
    chk("t4_state", state_c, 2'b00);
    wait_neg(1);
    chk("t4_abort_clr", abort, 2'b00);

    // Drop on the final S2 tick -> done wins
    do_reset(2'b01, 1'b1);
    wait_neg(12);
    req = 2'b00;
    wait_neg(1);
    chk("t5_done", done, 2'b01);
    chk("t5_abort", abort, 2'b00);
    chk("t5_state", state_c, 2'b00);

    // Reset mid-S1 at cnt=2, then re-grant
    do_reset(2'b01, 1'b1);
    wait_neg(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_rst", gnt, 2'b00);
    chk("t6_state_rst", state_c, 2'b00);
    chk("t6_busy_rst", {1'b0, busy}, 2'b00);
    chk("t6_pulses_rst", done | abort, 2'b00);
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(1);
    chk("t6_regrant", gnt, 2'b01);
    chk("t6_state", state_c, 2'b01);

    // Lone req[1] wins despite lp; non-owner ignored; owner drop lets req[0] in
    do_reset(2'b10, 1'b0);
    wait_neg(1);
    chk("t7_gnt", gnt, 2'b10);
    req = 2'b11;
    wait_neg(3);
    chk("t7_gnt_hold", gnt, 2'b10);
    chk("t7_state_hold", state_c, 2'b01);
    req = 2'b01;
    wait_neg(1);
    chk("t7_abort", abort, 2'b10);
    wait_neg(1);
    chk("t7_gnt_next", gnt, 2'b01);
    req = 2'b00;
    wait_neg(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
